// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared memory port and ALU,
// with a parametrised memory latency, retired-instruction counter and sticky illegal-opcode flag.
module mips_multicycle_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_wait;
  logic [5:0]       r_opcode;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic       w_mem_state, w_mem_done, w_set_illegal;
  logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write, w_retire;
  logic       w_i_or_d, w_mem_to_reg, w_reg_dst, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_mem_done  = (r_wait == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_mem_state && !w_mem_done) ? r_wait + 4'd1 : 4'd0;
      if (r_state == S_DECODE) r_opcode  <= opcode;
      if (w_set_illegal)       r_illegal <= 1'b1;
      if (w_retire)            r_count   <= r_count + 1'b1;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_i_or_d      = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_dst     = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_op      = 2'b00;
    w_pc_source   = 2'b00;
    w_retire      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (w_mem_done) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:       w_next = S_EXEC;
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_J:           w_next = S_JUMP;
          default: begin
            w_next        = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_i_or_d   = 1'b1;
        w_mem_read = 1'b1;
        w_next     = w_mem_done ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWR: begin
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = w_mem_done;
        w_next      = w_mem_done ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        // Branch target was precomputed in DECODE; the ALU now compares A and B.
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_source = 2'b01;
        w_retire    = 1'b1;
        w_pc_write  = (r_opcode == OP_BEQ) ? zero : ~zero;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_JUMP: begin
        w_pc_source = 2'b10;
        w_pc_write  = 1'b1;
        w_retire    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign pc_write    = w_pc_write  & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign mem_read    = w_mem_read  & ~rst;
  assign mem_write   = w_mem_write & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign retire      = w_retire    & ~rst;
  assign i_or_d      = w_i_or_d;
  assign mem_to_reg  = w_mem_to_reg;
  assign reg_dst     = w_reg_dst;
  assign alu_src_a   = w_alu_src_a;
  assign alu_src_b   = w_alu_src_b;
  assign alu_op      = w_alu_op;
  assign pc_source   = w_pc_source;
  assign illegal     = r_illegal;
  assign instr_count = r_count;
  assign state       = r_state;

endmodule
